// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - Shared types and helpers for the I/D memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  function automatic int beat_w(input int block_words);
    return (block_words > 1) ? $clog2(block_words) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - Combinational winner select between I and D requests.
// ARB_ROUND_ROBIN_EN: a tie goes to the side that was not granted last.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  logic last_id,
`endif
  output logic any_req,
  output logic win_id
);

  always_comb begin
    any_req = i_req | d_req;
    win_id  = REQ_D;
    if (i_req && !d_req) begin
      win_id = REQ_I;
    end
`ifdef ARB_ROUND_ROBIN_EN
    else if (i_req && d_req) begin
      win_id = (last_id == REQ_D) ? REQ_I : REQ_D;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Shares the main-memory port between I and D caches.
// Define ARB_ROUND_ROBIN_EN to alternate priority on simultaneous requests.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int ADDR_W      = 12,
  parameter  int DATA_W      = 32,
  parameter  int BLOCK_WORDS = 4,
  localparam int BEAT_W      = beat_w(BLOCK_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic [BEAT_W-1:0] beat_idx,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] WORD_MASK  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] BLOCK_MASK = ADDR_W'(BLOCK_WORDS * 4 - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BLOCK_WORDS - 1);

  state_e            state_q;
  logic              id_q;
  logic              we_q;
  logic [BEAT_W-1:0] cnt_q;
  logic [BEAT_W-1:0] beat_idx_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              i_gnt_q, i_rvalid_q, i_done_q;
  logic              d_gnt_q, d_rvalid_q, d_done_q;
  logic              mem_req_q, mem_we_q;

  logic              pick_any;
  logic              pick_id;
  logic              win_we;
  logic              accept;
  logic              last_beat;
  logic [ADDR_W-1:0] win_addr;
  logic [ADDR_W-1:0] start_addr;

`ifdef ARB_ROUND_ROBIN_EN
  logic              rr_q;
`endif

  mem_arb_pick u_pick (
    .i_req   (i_req),
    .d_req   (d_req),
`ifdef ARB_ROUND_ROBIN_EN
    .last_id (rr_q),
`endif
    .any_req (pick_any),
    .win_id  (pick_id)
  );

  // A done pulse on display blocks arbitration so a requester still holding
  // req on the edge that ends done is not granted a second time.
  always_comb begin
    win_addr   = (pick_id == REQ_D) ? d_addr : i_addr;
    win_we     = (pick_id == REQ_D) && d_we;
    start_addr = win_addr & ~(win_we ? WORD_MASK : BLOCK_MASK);
    accept     = pick_any && !i_done_q && !d_done_q;
    last_beat  = we_q || (cnt_q == LAST_BEAT);
    mem_addr_d = {mem_addr_q[ADDR_W-1:BEAT_W+2], BEAT_W'(cnt_q + 1'b1), 2'b00};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      id_q        <= REQ_D;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      beat_idx_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      i_gnt_q     <= 1'b0;
      i_rvalid_q  <= 1'b0;
      i_done_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_done_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_q        <= REQ_D;
`endif
    end else begin
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_done_q   <= 1'b0;
      d_done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            id_q        <= pick_id;
            we_q        <= win_we;
            cnt_q       <= '0;
            mem_addr_q  <= start_addr;
            mem_wdata_q <= (pick_id == REQ_D) ? d_wdata : '0;
            mem_we_q    <= win_we;
            mem_req_q   <= 1'b1;
            i_gnt_q     <= (pick_id == REQ_I);
            d_gnt_q     <= (pick_id == REQ_D);
`ifdef ARB_ROUND_ROBIN_EN
            rr_q        <= pick_id;
`endif
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!we_q) begin
              rdata_q    <= mem_rdata;
              beat_idx_q <= cnt_q;
              i_rvalid_q <= (id_q == REQ_I);
              d_rvalid_q <= (id_q == REQ_D);
            end
            if (last_beat) begin
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              state_q   <= DONE;
            end else begin
              cnt_q      <= cnt_q + 1'b1;
              mem_addr_q <= mem_addr_d;
            end
          end
        end
        DONE: begin
          i_done_q <= (id_q == REQ_I);
          d_done_q <= (id_q == REQ_D);
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_gnt     = i_gnt_q;
  assign i_rvalid  = i_rvalid_q;
  assign i_done    = i_done_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_done    = d_done_q;
  assign rdata     = rdata_q;
  assign beat_idx  = beat_idx_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - Randomized self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int BTW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_req, i_gnt, i_rvalid, i_done;
  logic [AW-1:0]  i_addr;
  logic           d_req, d_we, d_gnt, d_rvalid, d_done;
  logic [AW-1:0]  d_addr;
  logic [DW-1:0]  d_wdata;
  logic [DW-1:0]  rdata;
  logic [BTW-1:0] beat_idx;
  logic           mem_req, mem_we, mem_ready;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata, mem_rdata;

  int total = 0;
  int bad = 0;
  bit last_d = 1'b1;

  typedef struct {
    bit            side;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } txn_t;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ ({20'd0, a} * 32'h0001_9E37);
  endfunction

  assign mem_rdata = mem_fn(mem_addr);

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_done(d_done),
    .rdata(rdata), .beat_idx(beat_idx),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_flags"}, 32'({i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done, mem_req, mem_we}), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_beat_idx"}, 32'(beat_idx), 0);
  endtask

  // One transaction from grant to the cycle after its done pulse.
  task automatic serve(input txn_t t, input int stall_pct, input int stall_beat,
                       input int stall_len, input int exp_lat);
    int nb, k, cyc, stalled;
    bit got_gnt, done_seen, ready, completing;
    logic [AW-1:0] base;
    nb = t.we ? 1 : BW;
    base = t.we ? (t.addr & ~AW'(3)) : (t.addr & ~AW'(BW * 4 - 1));
    got_gnt = 1'b0;
    cyc = 0;
    for (int w = 0; w < 8 && !got_gnt; w++) begin
      mem_ready = 1'($urandom_range(1));
      @(negedge clk);
      cyc++;
      if (i_gnt || d_gnt) got_gnt = 1'b1;
    end
    chk("gnt_seen", 32'(got_gnt), 1);
    if (!got_gnt) begin
      i_req = 1'b0;
      d_req = 1'b0;
      return;
    end
    chk("gnt_side", 32'({i_gnt, d_gnt}), t.side ? 32'd1 : 32'd2);
    last_d = t.side;
    if (t.side) begin
      d_addr = AW'($urandom);
      d_wdata = $urandom;
      d_we = ~d_we;
    end else begin
      i_addr = AW'($urandom);
    end
    k = 0;
    stalled = 0;
    done_seen = 1'b0;
    while (!done_seen && cyc < 300) begin
      if (k < nb) begin
        chk("mem_req", 32'(mem_req), 1);
        chk("mem_addr", 32'(mem_addr), 32'(base) + 32'(4 * k));
        chk("mem_we", 32'(mem_we), 32'(t.we));
        if (t.we) chk("mem_wdata", mem_wdata, t.wd);
        if (k == stall_beat && stalled < stall_len) begin
          ready = 1'b0;
          stalled++;
        end else begin
          ready = ($urandom_range(99) >= 32'(stall_pct));
        end
      end else begin
        chk("mem_req_off", 32'(mem_req), 0);
        ready = 1'($urandom_range(1));
      end
      mem_ready = ready;
      completing = (k < nb) && ready;
      @(negedge clk);
      cyc++;
      chk("gnt_pulse", 32'({i_gnt, d_gnt}), 0);
      if (completing && !t.we) begin
        chk("rvalid", 32'({i_rvalid, d_rvalid}), t.side ? 32'd1 : 32'd2);
        chk("rdata", rdata, mem_fn(AW'(32'(base) + 32'(4 * k))));
        chk("beat_idx", 32'(beat_idx), 32'(k));
      end else begin
        chk("rvalid_idle", 32'({i_rvalid, d_rvalid}), 0);
      end
      if (completing) k++;
      if (i_done || d_done) begin
        done_seen = 1'b1;
        chk("done_side", 32'({i_done, d_done}), t.side ? 32'd1 : 32'd2);
        chk("done_beats", 32'(k), 32'(nb));
      end
    end
    chk("done_seen", 32'(done_seen), 1);
    if (exp_lat > 0) chk("latency", 32'(cyc), 32'(exp_lat));
    if (t.side) d_req = 1'b0;
    else i_req = 1'b0;
    @(negedge clk);
    chk("done_once", 32'({i_done, d_done}), 0);
  endtask

  task automatic run(input bit ie, input logic [AW-1:0] ia, input bit de, input bit dwe,
                     input logic [AW-1:0] da, input logic [DW-1:0] dwd,
                     input int stall_pct, input int stall_beat, input int stall_len,
                     input int exp_lat);
    txn_t ti, td;
    bit i_first;
    ti.side = 1'b0; ti.we = 1'b0; ti.addr = ia; ti.wd = '0;
    td.side = 1'b1; td.we = dwe;  td.addr = da; td.wd = dwd;
    i_req = ie; i_addr = ia;
    d_req = de; d_we = dwe; d_addr = da; d_wdata = dwd;
`ifdef ARB_ROUND_ROBIN_EN
    i_first = last_d;
`else
    i_first = 1'b0;
`endif
    if (ie && de) begin
      if (i_first) begin
        serve(ti, stall_pct, stall_beat, stall_len, 0);
        serve(td, stall_pct, stall_beat, stall_len, 0);
      end else begin
        serve(td, stall_pct, stall_beat, stall_len, 0);
        serve(ti, stall_pct, stall_beat, stall_len, 0);
      end
    end else if (de) begin
      serve(td, stall_pct, stall_beat, stall_len, exp_lat);
    end else if (ie) begin
      serve(ti, stall_pct, stall_beat, stall_len, exp_lat);
    end
  endtask

  initial begin
    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);

    run(1'b1, 12'h124, 1'b0, 1'b0, 12'h000, 32'h0, 0, -1, 0, 6);
    run(1'b0, 12'h000, 1'b1, 1'b1, 12'h040, 32'hDEADBEEF, 0, -1, 0, 3);
    run(1'b1, 12'h200, 1'b1, 1'b0, 12'h38C, 32'h0, 0, -1, 0, 0);
    run(1'b1, 12'h51C, 1'b1, 1'b1, 12'h0F8, 32'h1234_5678, 0, -1, 0, 0);
    run(1'b1, 12'h0A0, 1'b0, 1'b0, 12'h000, 32'h0, 0, 2, 3, 9);

    i_req = 1'b1; i_addr = 12'h300; d_req = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    chk("rst_case_gnt", 32'(i_gnt), 1);
    @(negedge clk);
    chk("rst_case_beat0", 32'(i_rvalid), 1);
    chk("rst_case_beat1_addr", 32'(mem_addr), 32'h304);
    #2 rst = 1'b1;
    #1 chk_reset("mid_burst_rst");
    @(negedge clk);
    rst = 1'b0;
    last_d = 1'b1;
    run(1'b1, 12'h300, 1'b0, 1'b0, 12'h000, 32'h0, 0, -1, 0, 6);

    run(1'b0, 12'h000, 1'b1, 1'b1, 12'h050, 32'hCAFE_F00D, 0, -1, 0, 3);
    run(1'b0, 12'h000, 1'b1, 1'b0, 12'h1F4, 32'h0, 0, -1, 0, 6);

    for (int n = 0; n < 40; n++) begin
      bit ie, de, dwe;
      ie = 1'($urandom_range(1));
      de = 1'($urandom_range(1));
      dwe = 1'($urandom_range(1));
      if (!ie && !de) ie = 1'b1;
      run(ie, AW'($urandom) & 12'hFFC, de, dwe, AW'($urandom) & 12'hFFC, $urandom,
          int'($urandom_range(60)), -1, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    chk("watchdog", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
